// File: rtl/game_tick_sequencer.sv
// Per-tick scheduler: starts the player, enemy and projectile updaters one at a time,
// hands each of them the grid port in turn, then requests a render of the frame.
`timescale 1ns/1ps
module game_tick_sequencer #(
    parameter int unsigned TICK_CYCLES    = 2000000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    output logic [2:0]  client_start,
    input  logic [2:0]  client_done,
    input  logic [17:0] client_grid_x,
    input  logic [14:0] client_grid_y,
    input  logic [2:0]  client_grid_write,
    input  logic [8:0]  client_grid_in,
    output logic [5:0]  grid_x,
    output logic [4:0]  grid_y,
    output logic        grid_write,
    output logic [2:0]  grid_in,
    output logic        render_start,
    input  logic        render_done,
    output logic        busy,
    output logic [2:0]  timeout_flags,
    output logic [7:0]  overrun_count,
    output logic [15:0] frame_count
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RENDER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] tmo_q, tmo_d;
    logic [2:0]  flags_q, flags_d;
    logic [7:0]  overrun_q, overrun_d;
    logic [15:0] frames_q, frames_d;
    logic [31:0] tick_cnt_q;
    logic        tick;
    logic [2:0]  grant;
    logic        owner_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tick = enable && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
        end else if (!enable || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    // One-hot grant of the current owner; empty outside RUN
    always_comb begin
        grant = 3'b000;
        if (state_q == RUN) begin
            case (owner_q)
                2'd0:    grant = 3'b001;
                2'd1:    grant = 3'b010;
                2'd2:    grant = 3'b100;
                default: grant = 3'b000;
            endcase
        end
    end

    assign owner_done = |(client_done & grant);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tmo_d     = tmo_q;
        flags_d   = flags_q;
        overrun_d = overrun_q;
        frames_d  = frames_q;

        if (tick && (state_q != IDLE)) begin
            overrun_d = sat_inc8(overrun_q);
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RUN;
                    owner_d = 2'd0;
                    tmo_d   = '0;
                end
            end
            RUN: begin
                // A done pulse in the timeout cycle wins, so no flag is raised
                if (owner_done || (tmo_q == TMO_LAST)) begin
                    if (!owner_done) begin
                        flags_d = flags_q | grant;
                    end
                    if (owner_q == 2'd2) begin
                        state_d = RENDER;
                    end else begin
                        owner_d = owner_q + 2'd1;
                        tmo_d   = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RENDER: begin
                if (render_done) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            tmo_q     <= '0;
            flags_q   <= '0;
            overrun_q <= '0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tmo_q     <= tmo_d;
            flags_q   <= flags_d;
            overrun_q <= overrun_d;
            frames_q  <= frames_d;
        end
    end

    always_comb begin
        grid_x     = '0;
        grid_y     = '0;
        grid_write = 1'b0;
        grid_in    = '0;
        if (state_q == RUN) begin
            case (owner_q)
                2'd0: begin
                    grid_x     = client_grid_x[5:0];
                    grid_y     = client_grid_y[4:0];
                    grid_write = client_grid_write[0];
                    grid_in    = client_grid_in[2:0];
                end
                2'd1: begin
                    grid_x     = client_grid_x[11:6];
                    grid_y     = client_grid_y[9:5];
                    grid_write = client_grid_write[1];
                    grid_in    = client_grid_in[5:3];
                end
                2'd2: begin
                    grid_x     = client_grid_x[17:12];
                    grid_y     = client_grid_y[14:10];
                    grid_write = client_grid_write[2];
                    grid_in    = client_grid_in[8:6];
                end
                default: ;
            endcase
        end
    end

    assign client_start  = grant;
    assign render_start  = (state_q == RENDER);
    assign busy          = (state_q != IDLE);
    assign timeout_flags = flags_q;
    assign overrun_count = overrun_q;
    assign frame_count   = frames_q;

endmodule
